rename_regfile: RTL and testbench

//  Parametrised rename register file between decode and ROB dispatch. Holds architectural GPRs and NZCV.

---
 rtl/rename_regfile_pkg.sv | 58 +++++
 rtl/rename_regfile_operand_resolve.sv | 40 ++++
 rtl/rename_regfile.sv | 225 ++++++++++++++++++++++
 tb/tb_rename_regfile.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared types for the rename register file: operand status, NZCV, register entry and
// the functional-unit fields that pass through to dispatch untouched.
package rename_regfile_pkg;

    localparam int DEF_DATA_W    = 64;
    localparam int DEF_ROB_IDX_W = 4;

    typedef enum logic [2:0] {
        SRC_UNUSED = 3'd0,
        SRC_USED   = 3'd1,
        SRC_XZR    = 3'd2,
        SRC_PC     = 3'd3,
        SRC_IMM    = 3'd4
    } src_stat_t;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]    value;
        logic                     valid;
        logic [DEF_ROB_IDX_W-1:0] tag;
    } gpr_entry_t;

    typedef enum logic [2:0] {
        FU_ALU  = 3'd0,
        FU_MUL  = 3'd1,
        FU_LSU  = 3'd2,
        FU_BR   = 3'd3,
        FU_NONE = 3'd7
    } fu_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_ORR = 4'd3,
        OP_EOR = 4'd4,
        OP_LSL = 4'd5,
        OP_LSR = 4'd6,
        OP_MUL = 4'd7,
        OP_LDR = 4'd8,
        OP_STR = 4'd9,
        OP_B   = 4'd10
    } fu_op_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_AL = 4'd14
    } cond_t;

endpackage

// File: rtl/rename_regfile_operand_resolve.sv
// Per-operand select: forced zero, constant (PC/immediate) or register entry, with a bypass
// from a same-cycle commit whose tag matches the register's pending producer.
module rr_operand_resolve #(
    parameter int DATA_W    = 64,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 force_zero,
    input  logic                 use_const,
    input  logic [DATA_W-1:0]    const_value,
    input  logic                 reg_valid,
    input  logic [DATA_W-1:0]    reg_value,
    input  logic [ROB_IDX_W-1:0] reg_tag,
    input  logic                 commit_hit,
    input  logic [ROB_IDX_W-1:0] commit_idx,
    input  logic [DATA_W-1:0]    commit_value,
    output logic                 op_valid,
    output logic [DATA_W-1:0]    op_value,
    output logic [ROB_IDX_W-1:0] op_rob_idx
);

    always_comb begin
        op_valid   = 1'b1;
        op_value   = '0;
        op_rob_idx = '0;
        if (force_zero) begin
            op_valid = 1'b1;
        end else if (use_const) begin
            op_value = const_value;
        end else begin
            op_valid   = reg_valid;
            op_value   = reg_value;
            op_rob_idx = reg_tag;
            if (!reg_valid && commit_hit && (commit_idx == reg_tag)) begin
                op_valid = 1'b1;
                op_value = commit_value;
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Rename register file: resolves source operands to values or producer ROB tags, renames
// destinations/NZCV at dispatch, and restores architectural state on a mispredict flush.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int GPR_COUNT = 32,
    parameter int DATA_W    = 64,
    parameter int ROB_IDX_W = 4,
    parameter int XZR_IDX   = 31,
    localparam int REG_W    = $clog2(GPR_COUNT)
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_d_valid,
    output logic                 out_d_ready,
    input  logic [REG_W-1:0]     in_d_src1,
    input  logic [REG_W-1:0]     in_d_src2,
    input  src_stat_t            in_d_src1_status,
    input  src_stat_t            in_d_src2_status,
    input  logic [REG_W-1:0]     in_d_dst,
    input  logic                 in_d_writes_dst,
    input  logic                 in_d_set_nzcv,
    input  logic                 in_d_uses_nzcv,
    input  logic [DATA_W-1:0]    in_d_imm,
    input  logic [DATA_W-1:0]    in_d_pc,
    input  fu_t                  in_d_fu_id,
    input  fu_op_t               in_d_fu_op,
    input  cond_t                in_d_cond,
    input  logic [ROB_IDX_W-1:0] in_rob_next_idx,
    input  logic                 in_rob_ready,
    input  logic                 in_commit_valid,
    input  logic [REG_W-1:0]     in_commit_reg,
    input  logic [ROB_IDX_W-1:0] in_commit_idx,
    input  logic [DATA_W-1:0]    in_commit_value,
    input  logic                 in_commit_set_nzcv,
    input  nzcv_t                in_commit_nzcv,
    input  logic                 in_flush,
    output logic                 out_valid,
    output logic                 out_src1_valid,
    output logic [DATA_W-1:0]    out_src1_value,
    output logic [ROB_IDX_W-1:0] out_src1_rob_idx,
    output logic                 out_src2_valid,
    output logic [DATA_W-1:0]    out_src2_value,
    output logic [ROB_IDX_W-1:0] out_src2_rob_idx,
    output logic                 out_nzcv_valid,
    output nzcv_t                out_nzcv,
    output logic [ROB_IDX_W-1:0] out_nzcv_rob_idx,
    output logic [REG_W-1:0]     out_dst,
    output logic                 out_writes_dst,
    output logic                 out_set_nzcv,
    output logic                 out_uses_nzcv,
    output logic [DATA_W-1:0]    out_pc,
    output fu_t                  out_fu_id,
    output fu_op_t               out_fu_op,
    output cond_t                out_cond
);

    localparam logic [REG_W-1:0] XZR = REG_W'(XZR_IDX);

    logic [DATA_W-1:0]    gpr_value [GPR_COUNT];
    logic [ROB_IDX_W-1:0] gpr_tag   [GPR_COUNT];
    logic [GPR_COUNT-1:0] gpr_valid;
    nzcv_t                nzcv_value;
    logic                 nzcv_valid;
    logic [ROB_IDX_W-1:0] nzcv_tag;

    logic                 accept;
    logic                 commit_gpr;
    logic                 commit_nzcv;
    logic                 res1_valid, res2_valid, resn_valid;
    logic [DATA_W-1:0]    res1_value, res2_value;
    nzcv_t                resn_value;
    logic [ROB_IDX_W-1:0] res1_idx, res2_idx, resn_idx;

    assign out_d_ready = ~in_flush & (~out_valid | in_rob_ready);
    assign accept      = in_d_valid & out_d_ready;
    assign commit_gpr  = in_commit_valid & (in_commit_reg != XZR);
    assign commit_nzcv = in_commit_valid & in_commit_set_nzcv;

    rr_operand_resolve #(.DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) u_src1 (
        .force_zero  ((in_d_src1_status == SRC_XZR) | (in_d_src1 == XZR) |
                      (in_d_src1_status == SRC_UNUSED)),
        .use_const   (in_d_src1_status == SRC_PC),
        .const_value (in_d_pc),
        .reg_valid   (gpr_valid[in_d_src1]),
        .reg_value   (gpr_value[in_d_src1]),
        .reg_tag     (gpr_tag[in_d_src1]),
        .commit_hit  (commit_gpr & (in_commit_reg == in_d_src1)),
        .commit_idx  (in_commit_idx),
        .commit_value(in_commit_value),
        .op_valid    (res1_valid),
        .op_value    (res1_value),
        .op_rob_idx  (res1_idx)
    );

    rr_operand_resolve #(.DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) u_src2 (
        .force_zero  ((in_d_src2_status == SRC_XZR) | (in_d_src2 == XZR) |
                      (in_d_src2_status == SRC_UNUSED)),
        .use_const   (in_d_src2_status == SRC_IMM),
        .const_value (in_d_imm),
        .reg_valid   (gpr_valid[in_d_src2]),
        .reg_value   (gpr_value[in_d_src2]),
        .reg_tag     (gpr_tag[in_d_src2]),
        .commit_hit  (commit_gpr & (in_commit_reg == in_d_src2)),
        .commit_idx  (in_commit_idx),
        .commit_value(in_commit_value),
        .op_valid    (res2_valid),
        .op_value    (res2_value),
        .op_rob_idx  (res2_idx)
    );

    rr_operand_resolve #(.DATA_W(4), .ROB_IDX_W(ROB_IDX_W)) u_nzcv (
        .force_zero  (~in_d_uses_nzcv),
        .use_const   (1'b0),
        .const_value (4'h0),
        .reg_valid   (nzcv_valid),
        .reg_value   (nzcv_value),
        .reg_tag     (nzcv_tag),
        .commit_hit  (commit_nzcv),
        .commit_idx  (in_commit_idx),
        .commit_value(in_commit_nzcv),
        .op_valid    (resn_valid),
        .op_value    (resn_value),
        .op_rob_idx  (resn_idx)
    );

    // Later assignments win: commit, then rename (younger producer), then flush restores all.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < GPR_COUNT; i++) begin
                gpr_value[i] <= '0;
                gpr_tag[i]   <= '0;
            end
            gpr_valid  <= '1;
            nzcv_value <= '0;
            nzcv_valid <= 1'b1;
            nzcv_tag   <= '0;
        end else begin
            if (commit_gpr) begin
                gpr_value[in_commit_reg] <= in_commit_value;
                if (gpr_tag[in_commit_reg] == in_commit_idx)
                    gpr_valid[in_commit_reg] <= 1'b1;
            end
            if (commit_nzcv) begin
                nzcv_value <= in_commit_nzcv;
                if (nzcv_tag == in_commit_idx)
                    nzcv_valid <= 1'b1;
            end
            if (in_flush) begin
                gpr_valid  <= '1;
                nzcv_valid <= 1'b1;
            end else if (accept) begin
                if (in_d_writes_dst && (in_d_dst != XZR)) begin
                    gpr_valid[in_d_dst] <= 1'b0;
                    gpr_tag[in_d_dst]   <= in_rob_next_idx;
                end
                if (in_d_set_nzcv) begin
                    nzcv_valid <= 1'b0;
                    nzcv_tag   <= in_rob_next_idx;
                end
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_valid        <= 1'b0;
            out_src1_valid   <= 1'b0;
            out_src1_value   <= '0;
            out_src1_rob_idx <= '0;
            out_src2_valid   <= 1'b0;
            out_src2_value   <= '0;
            out_src2_rob_idx <= '0;
            out_nzcv_valid   <= 1'b0;
            out_nzcv         <= '0;
            out_nzcv_rob_idx <= '0;
            out_dst          <= '0;
            out_writes_dst   <= 1'b0;
            out_set_nzcv     <= 1'b0;
            out_uses_nzcv    <= 1'b0;
            out_pc           <= '0;
            out_fu_id        <= fu_t'('0);
            out_fu_op        <= fu_op_t'('0);
            out_cond         <= cond_t'('0);
        end else if (in_flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid        <= 1'b1;
            out_src1_valid   <= res1_valid;
            out_src1_value   <= res1_value;
            out_src1_rob_idx <= res1_idx;
            out_src2_valid   <= res2_valid;
            out_src2_value   <= res2_value;
            out_src2_rob_idx <= res2_idx;
            out_nzcv_valid   <= resn_valid;
            out_nzcv         <= resn_value;
            out_nzcv_rob_idx <= resn_idx;
            out_dst          <= in_d_dst;
            out_writes_dst   <= in_d_writes_dst;
            out_set_nzcv     <= in_d_set_nzcv;
            out_uses_nzcv    <= in_d_uses_nzcv;
            out_pc           <= in_d_pc;
            out_fu_id        <= in_d_fu_id;
            out_fu_op        <= in_d_fu_op;
            out_cond         <= in_d_cond;
        end else if (out_valid && in_rob_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid && in_commit_valid) begin
            // Held bundle: wake operands whose producer commits while the ROB stalls.
            if (!out_src1_valid && (out_src1_rob_idx == in_commit_idx)) begin
                out_src1_valid <= 1'b1;
                out_src1_value <= in_commit_value;
            end
            if (!out_src2_valid && (out_src2_rob_idx == in_commit_idx)) begin
                out_src2_valid <= 1'b1;
                out_src2_value <= in_commit_value;
            end
            if (in_commit_set_nzcv && !out_nzcv_valid && (out_nzcv_rob_idx == in_commit_idx)) begin
                out_nzcv_valid <= 1'b1;
                out_nzcv       <= in_commit_nzcv;
            end
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: reset, operand resolution, rename/commit tag rules,
// bypass, held-output wakeup and flush recovery.
module tb_rename_regfile;
    import rename_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid, d_ready;
    logic [4:0]  d_src1, d_src2, d_dst;
    src_stat_t   d_src1_status, d_src2_status;
    logic        d_writes_dst, d_set_nzcv, d_uses_nzcv;
    logic [63:0] d_imm, d_pc;
    fu_t         d_fu_id;
    fu_op_t      d_fu_op;
    cond_t       d_cond;
    logic [3:0]  rob_next_idx;
    logic        rob_ready;
    logic        c_valid;
    logic [4:0]  c_reg;
    logic [3:0]  c_idx;
    logic [63:0] c_value;
    logic        c_set_nzcv;
    nzcv_t       c_nzcv;
    logic        flush;

    logic        o_valid, o_s1_valid, o_s2_valid, o_n_valid;
    logic [63:0] o_s1_value, o_s2_value, o_pc;
    logic [3:0]  o_s1_idx, o_s2_idx, o_n_idx;
    nzcv_t       o_nzcv;
    logic [4:0]  o_dst;
    logic        o_writes_dst, o_set_nzcv, o_uses_nzcv;
    fu_t         o_fu_id;
    fu_op_t      o_fu_op;
    cond_t       o_cond;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rename_regfile dut (
        .in_clk(clk), .in_rst(rst),
        .in_d_valid(d_valid), .out_d_ready(d_ready),
        .in_d_src1(d_src1), .in_d_src2(d_src2),
        .in_d_src1_status(d_src1_status), .in_d_src2_status(d_src2_status),
        .in_d_dst(d_dst), .in_d_writes_dst(d_writes_dst),
        .in_d_set_nzcv(d_set_nzcv), .in_d_uses_nzcv(d_uses_nzcv),
        .in_d_imm(d_imm), .in_d_pc(d_pc),
        .in_d_fu_id(d_fu_id), .in_d_fu_op(d_fu_op), .in_d_cond(d_cond),
        .in_rob_next_idx(rob_next_idx), .in_rob_ready(rob_ready),
        .in_commit_valid(c_valid), .in_commit_reg(c_reg), .in_commit_idx(c_idx),
        .in_commit_value(c_value), .in_commit_set_nzcv(c_set_nzcv), .in_commit_nzcv(c_nzcv),
        .in_flush(flush),
        .out_valid(o_valid),
        .out_src1_valid(o_s1_valid), .out_src1_value(o_s1_value), .out_src1_rob_idx(o_s1_idx),
        .out_src2_valid(o_s2_valid), .out_src2_value(o_s2_value), .out_src2_rob_idx(o_s2_idx),
        .out_nzcv_valid(o_n_valid), .out_nzcv(o_nzcv), .out_nzcv_rob_idx(o_n_idx),
        .out_dst(o_dst), .out_writes_dst(o_writes_dst), .out_set_nzcv(o_set_nzcv),
        .out_uses_nzcv(o_uses_nzcv), .out_pc(o_pc),
        .out_fu_id(o_fu_id), .out_fu_op(o_fu_op), .out_cond(o_cond)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] s1, input src_stat_t st1, input logic [4:0] s2,
                         input src_stat_t st2, input logic [63:0] imm, input logic [4:0] dst,
                         input logic wd, input logic [3:0] nidx);
        d_valid = 1'b1;
        d_src1 = s1; d_src1_status = st1;
        d_src2 = s2; d_src2_status = st2;
        d_imm = imm; d_dst = dst; d_writes_dst = wd;
        d_set_nzcv = 1'b0; d_uses_nzcv = 1'b0;
        rob_next_idx = nidx;
    endtask

    task automatic commit(input logic [4:0] r, input logic [3:0] idx, input logic [63:0] v);
        c_valid = 1'b1; c_reg = r; c_idx = idx; c_value = v;
        c_set_nzcv = 1'b0; c_nzcv = 4'h0;
    endtask

    initial begin
        rst = 1'b1; d_valid = 1'b0; rob_ready = 1'b1; flush = 1'b0;
        d_src1 = '0; d_src2 = '0; d_dst = '0;
        d_src1_status = SRC_UNUSED; d_src2_status = SRC_UNUSED;
        d_writes_dst = 1'b0; d_set_nzcv = 1'b0; d_uses_nzcv = 1'b0;
        d_imm = '0; d_pc = 64'h1000; d_fu_id = FU_ALU; d_fu_op = OP_ADD; d_cond = COND_AL;
        rob_next_idx = '0;
        c_valid = 1'b0; c_reg = '0; c_idx = '0; c_value = '0; c_set_nzcv = 1'b0; c_nzcv = 4'h0;
        repeat (2) tick();
        check("rst_out_valid", 64'(o_valid), 64'd0);
        check("rst_src1_valid", 64'(o_s1_valid), 64'd0);
        check("rst_src2_value", o_s2_value, 64'd0);
        check("rst_nzcv_valid", 64'(o_n_valid), 64'd0);
        check("rst_d_ready", 64'(d_ready), 64'd1);
        rst = 1'b0;

        // 1: X3 after reset plus immediate
        issue(5'd3, SRC_USED, 5'd5, SRC_IMM, 64'd7, 5'd0, 1'b0, 4'd0);
        tick();
        check("t1_out_valid", 64'(o_valid), 64'd1);
        check("t1_src1_valid", 64'(o_s1_valid), 64'd1);
        check("t1_src1_value", o_s1_value, 64'd0);
        check("t1_src2_valid", 64'(o_s2_valid), 64'd1);
        check("t1_src2_value", o_s2_value, 64'd7);

        // 2: rename X1 -> 5, read, commit 42, read
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd1, 1'b1, 4'd5);
        tick();
        issue(5'd1, SRC_USED, 5'd0, SRC_UNUSED, 64'd0, 5'd0, 1'b0, 4'd0);
        tick();
        check("t2_src1_valid", 64'(o_s1_valid), 64'd0);
        check("t2_src1_idx", 64'(o_s1_idx), 64'd5);
        d_valid = 1'b0;
        commit(5'd1, 4'd5, 64'd42);
        tick();
        check("t2_drain", 64'(o_valid), 64'd0);
        c_valid = 1'b0;
        issue(5'd1, SRC_USED, 5'd0, SRC_UNUSED, 64'd0, 5'd0, 1'b0, 4'd0);
        tick();
        check("t2_commit_valid", 64'(o_s1_valid), 64'd1);
        check("t2_commit_value", o_s1_value, 64'd42);

        // 3: X2 renamed 3 then 6; commit of 3 leaves X2 pending on 6
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd2, 1'b1, 4'd3);
        tick();
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd2, 1'b1, 4'd6);
        tick();
        d_valid = 1'b0;
        commit(5'd2, 4'd3, 64'd9);
        tick();
        c_valid = 1'b0;
        issue(5'd0, SRC_UNUSED, 5'd2, SRC_USED, 64'd0, 5'd0, 1'b0, 4'd0);
        tick();
        check("t3_src2_valid", 64'(o_s2_valid), 64'd0);
        check("t3_src2_idx", 64'(o_s2_idx), 64'd6);
        check("t3_src2_value", o_s2_value, 64'd9);

        // 4: held bundle woken by commit
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd3, 1'b1, 4'd4);
        tick();
        issue(5'd3, SRC_USED, 5'd0, SRC_UNUSED, 64'd0, 5'd0, 1'b0, 4'd0);
        tick();
        check("t4_src1_pending", 64'(o_s1_valid), 64'd0);
        check("t4_src1_idx", 64'(o_s1_idx), 64'd4);
        d_valid = 1'b0;
        rob_ready = 1'b0;
        tick();
        check("t4_hold_valid", 64'(o_valid), 64'd1);
        check("t4_hold_ready", 64'(d_ready), 64'd0);
        commit(5'd3, 4'd4, 64'h55);
        tick();
        check("t4_wake_valid", 64'(o_s1_valid), 64'd1);
        check("t4_wake_value", o_s1_value, 64'h55);
        check("t4_still_held", 64'(o_valid), 64'd1);
        c_valid = 1'b0;
        rob_ready = 1'b1;
        tick();
        check("t4_release", 64'(o_valid), 64'd0);

        // 5: src == dst reads the old tag
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd4, 1'b1, 4'd2);
        tick();
        issue(5'd4, SRC_USED, 5'd0, SRC_UNUSED, 64'd0, 5'd4, 1'b1, 4'd7);
        tick();
        check("t5_old_tag", 64'(o_s1_idx), 64'd2);
        check("t5_old_pending", 64'(o_s1_valid), 64'd0);
        issue(5'd4, SRC_USED, 5'd0, SRC_UNUSED, 64'd0, 5'd0, 1'b0, 4'd0);
        tick();
        check("t5_new_tag", 64'(o_s1_idx), 64'd7);

        // same-cycle commit bypass into an accepted operand
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd5, 1'b1, 4'd8);
        tick();
        issue(5'd5, SRC_USED, 5'd0, SRC_UNUSED, 64'd0, 5'd0, 1'b0, 4'd0);
        commit(5'd5, 4'd8, 64'h77);
        tick();
        check("byp_valid", 64'(o_s1_valid), 64'd1);
        check("byp_value", o_s1_value, 64'h77);
        c_valid = 1'b0;

        // NZCV rename and commit
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd0, 1'b0, 4'd9);
        d_set_nzcv = 1'b1;
        tick();
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd0, 1'b0, 4'd0);
        d_uses_nzcv = 1'b1;
        tick();
        check("nzcv_pending", 64'(o_n_valid), 64'd0);
        check("nzcv_idx", 64'(o_n_idx), 64'd9);
        d_valid = 1'b0;
        commit(5'd31, 4'd9, 64'd0);
        c_set_nzcv = 1'b1; c_nzcv = 4'hA;
        tick();
        c_valid = 1'b0; c_set_nzcv = 1'b0;
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd0, 1'b0, 4'd0);
        d_uses_nzcv = 1'b1;
        tick();
        check("nzcv_valid", 64'(o_n_valid), 64'd1);
        check("nzcv_value", 64'(o_nzcv), 64'hA);

        // XZR index outranks IMM status; PC status on src1
        issue(5'd31, SRC_USED, 5'd31, SRC_IMM, 64'd99, 5'd0, 1'b0, 4'd0);
        tick();
        check("xzr_src1", o_s1_value, 64'd0);
        check("xzr_src2_imm", o_s2_value, 64'd0);
        issue(5'd2, SRC_PC, 5'd0, SRC_UNUSED, 64'd0, 5'd0, 1'b0, 4'd0);
        tick();
        check("pc_src1", o_s1_value, 64'h1000);

        // 6: flush with pending renames and a same-cycle commit
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd1, 1'b1, 4'd11);
        tick();
        issue(5'd0, SRC_UNUSED, 5'd0, SRC_UNUSED, 64'd0, 5'd6, 1'b1, 4'd12);
        tick();
        issue(5'd1, SRC_USED, 5'd0, SRC_UNUSED, 64'd0, 5'd7, 1'b1, 4'd13);
        flush = 1'b1;
        commit(5'd1, 4'd11, 64'd11);
        #1;
        check("flush_ready", 64'(d_ready), 64'd0);
        tick();
        check("flush_out_valid", 64'(o_valid), 64'd0);
        flush = 1'b0;
        c_valid = 1'b0;
        issue(5'd1, SRC_USED, 5'd6, SRC_USED, 64'd0, 5'd0, 1'b0, 4'd0);
        tick();
        check("flush_x1_valid", 64'(o_s1_valid), 64'd1);
        check("flush_x1_value", o_s1_value, 64'd11);
        check("flush_x6_valid", 64'(o_s2_valid), 64'd1);
        check("flush_x6_value", o_s2_value, 64'd0);
        issue(5'd7, SRC_USED, 5'd31, SRC_USED, 64'd0, 5'd0, 1'b0, 4'd0);
        tick();
        check("flush_x7_valid", 64'(o_s1_valid), 64'd1);
        check("flush_xzr_valid", 64'(o_s2_valid), 64'd1);
        check("flush_xzr_value", o_s2_value, 64'd0);
        d_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
